regs_cmd_buffer: RTL and testbench
==================================

Name: regs_cmd_buffer

Overview:
- Command queue that sits between the register-bus initiator and ctrl_regs.
- Accepts RD/WR commands on the initiator-side cmd/addr/data bus and buffers them in a FIFO.
- Replays each command to ctrl_regs as a single-cycle pulse, then returns IDLE.
- For reads, captures cmd_data_o of ctrl_regs after a fixed latency and emits one response pulse.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- ADDR_W, 8, command address width.
- DATA_W, 32, data width.
- RD_LAT, 1, cycles from ctrl_regs sampling a RD to valid read data; ≥1.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- in_cmd_i  in  2  initiator command: IDLE=2'b00, RD=2'b01, WR=2'b10.
- in_addr_i  in  ADDR_W  initiator address.
- in_data_i  in  DATA_W  initiator write data.
- in_ready_o  out  1  queue can accept a command.
- hold_i  in  1  blocks launch of new commands.
- cmd_o  out  2  command to ctrl_regs (cmd_i).
- cmd_addr_o  out  ADDR_W  to ctrl_regs cmd_addr_i.
- cmd_data_o  out  DATA_W  to ctrl_regs cmd_data_i.
- rd_data_i  in  DATA_W  from ctrl_regs cmd_data_o.
- rsp_valid_o  out  1  one-cycle read-response pulse.
- rsp_addr_o  out  ADDR_W  address of the completed read.
- rsp_data_o  out  DATA_W  read data.
- level_o  out  $clog2(DEPTH+1)  FIFO occupancy.
- err_o  out  2  present only with REGS_CMD_BUF_ERR_EN.

Behaviour:
- Reset (async assert): FIFO empty; state S_IDLE; cmd_o=IDLE; cmd_addr_o, cmd_data_o, rsp_* and level_o = 0; in_ready_o=1; err_o=0. Deassertion is synchronous to clk_i.
- in_ready_o = (level_o != DEPTH), combinational from registered count.
- Push: at a posedge where in_cmd_i is RD or WR and in_ready_o=1, store {cmd, addr, data}. IDLE and 2'b11 are never stored. Commands presented while full are dropped.
- Push and pop in the same cycle: level unchanged. Fullness is judged on the pre-edge count, so a pop does not free a slot for a push in the same cycle.
- FSM states: S_IDLE, S_ISSUE, S_RDWAIT.
- Launch: when the FIFO is non-empty and hold_i=0, pop the head and register it onto cmd_o/cmd_addr_o/cmd_data_o. Launch is permitted in S_IDLE, and in S_ISSUE when the current command is WR.
- S_IDLE: on launch go to S_ISSUE; otherwise drive cmd_o=IDLE with addr and data 0.
- S_ISSUE (command visible for exactly one cycle; ctrl_regs samples it at the closing edge E0):
  - WR with launch possible: next command loads and FSM stays in S_ISSUE, giving back-to-back WRs on consecutive cycles.
  - WR otherwise: outputs return to IDLE/0, go to S_IDLE.
  - RD: latch the address into a response register, outputs return to IDLE/0, load wait counter = RD_LAT-1, go to S_RDWAIT.
- cmd_data_o is 0 for RD and IDLE.
- S_RDWAIT: lasts RD_LAT cycles; no launch. At the RD_LAT-th edge after E0, sample rd_data_i into rsp_data_o, set rsp_valid_o=1 for exactly one cycle, go to S_IDLE. A RD is therefore always followed by at least RD_LAT+1 non-command cycles.
- hold_i: gates only new launches. In-flight commands and read waits always complete.
- Reset mid-operation: queued commands and any in-flight read are discarded; no rsp_valid_o is produced.
- level_o counts entries in the FIFO. The command currently on cmd_o is not counted.

Optional Feature:
- Macro: REGS_CMD_BUF_ERR_EN.
- With macro: err_o[0] sets sticky when in_cmd_i==2'b11 at a posedge. err_o[1] sets sticky when RD/WR is presented while in_ready_o=0. Both clear only on reset.
- Without macro: err_o port and its logic are absent; such commands are silently dropped.

Test Plan:
- Reset, then idle 5 cycles -> cmd_o=00, level_o=0, in_ready_o=1, rsp_valid_o=0 throughout.
- Push WR addr 0x00 data 0x0000FFFF, then RD addr 0x00; ctrl_regs model returns 0x0000FFFF -> one WR cycle, then one RD cycle, then rsp_valid_o pulse with rsp_addr_o=0x00, rsp_data_o=0x0000FFFF.
- hold_i=1, push 5 WRs addr 0x10..0x14 -> in_ready_o=0 after 4th, level_o=4, 0x14 dropped; release hold_i -> WRs 0x10..0x13 on 4 consecutive cycles, then IDLE.
- RD_LAT=2, push RD 0x10 and RD 0x14; model data 0xA5A5_0010 / 0xA5A5_0014 -> two rsp pulses in order with matching data; ≥3 IDLE cycles between the two RD issues.
- Assert rstn_i during S_RDWAIT with 2 entries queued -> outputs 0 immediately, no rsp_valid_o, level_o=0 after release.
- With REGS_CMD_BUF_ERR_EN: drive in_cmd_i=2'b11 once -> err_o=2'b01 sticky, level_o unchanged; push while full -> err_o=2'b11.

Source files
------------

// File: rtl/regs_cmd_buffer.sv
// rtl/regs_cmd_buffer.sv - RD/WR command FIFO replaying single-cycle commands to ctrl_regs; optional err_o via REGS_CMD_BUF_ERR_EN
module regs_cmd_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [1:0]                 in_cmd_i,
  input  logic [ADDR_W-1:0]          in_addr_i,
  input  logic [DATA_W-1:0]          in_data_i,
  output logic                       in_ready_o,
  input  logic                       hold_i,
  output logic [1:0]                 cmd_o,
  output logic [ADDR_W-1:0]          cmd_addr_o,
  output logic [DATA_W-1:0]          cmd_data_o,
  input  logic [DATA_W-1:0]          rd_data_i,
  output logic                       rsp_valid_o,
  output logic [ADDR_W-1:0]          rsp_addr_o,
  output logic [DATA_W-1:0]          rsp_data_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
`ifdef REGS_CMD_BUF_ERR_EN
  ,
  output logic [1:0]                 err_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int ENT_W = 2 + ADDR_W + DATA_W;
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_RD   = 2'b01;
  localparam logic [1:0] CMD_WR   = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RDWAIT} state_e;

  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  count_q, count_d;

  state_e            state_q, state_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic              is_rdwr, push, launch;
  logic [ENT_W-1:0]  entry_in, head;

  // Only RD/WR are queued; write data is zeroed for RD so it never reaches cmd_data_o
  assign is_rdwr    = (in_cmd_i == CMD_RD) || (in_cmd_i == CMD_WR);
  assign in_ready_o = (count_q != LVL_W'(DEPTH));
  assign push       = is_rdwr && in_ready_o;
  assign entry_in   = {in_cmd_i, in_addr_i, (in_cmd_i == CMD_WR) ? in_data_i : {DATA_W{1'b0}}};
  assign head       = mem_q[rd_ptr_q];
  assign launch     = (count_q != '0) && !hold_i &&
                      ((state_q == S_IDLE) || ((state_q == S_ISSUE) && (cmd_q == CMD_WR)));

  // FIFO storage; contents are don't-care while empty so no reset is needed
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= entry_in;
  end

  // Occupancy; a same-cycle pop never frees a slot for the push judged on the old count
  always_comb begin
    count_d = count_q;
    case ({push, launch})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and count
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)   wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (launch) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Issue FSM: outputs default to IDLE/0 so every command is a one-cycle pulse
  always_comb begin
    state_d     = state_q;
    cmd_d       = CMD_IDLE;
    addr_d      = '0;
    data_d      = '0;
    wait_d      = wait_q;
    rsp_valid_d = 1'b0;
    rsp_addr_d  = rsp_addr_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          cmd_d   = head[ENT_W-1 -: 2];
          addr_d  = head[DATA_W +: ADDR_W];
          data_d  = head[DATA_W-1:0];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd_q == CMD_WR) begin
          if (launch) begin
            cmd_d  = head[ENT_W-1 -: 2];
            addr_d = head[DATA_W +: ADDR_W];
            data_d = head[DATA_W-1:0];
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          rsp_addr_d = addr_q;
          wait_d     = CNT_W'(RD_LAT - 1);
          state_d    = S_RDWAIT;
        end
      end
      S_RDWAIT: begin
        if (wait_q == '0) begin
          rsp_data_d  = rd_data_i;
          rsp_valid_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          wait_d = wait_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and output registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      cmd_q       <= CMD_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      wait_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wait_q      <= wait_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmd_o       = cmd_q;
  assign cmd_addr_o  = addr_q;
  assign cmd_data_o  = data_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_addr_o  = rsp_addr_q;
  assign rsp_data_o  = rsp_data_q;
  assign level_o     = count_q;

`ifdef REGS_CMD_BUF_ERR_EN
  logic [1:0] err_q;

  // Sticky flags: bit0 reserved encoding seen, bit1 command dropped while full
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      err_q <= '0;
    end else begin
      if (in_cmd_i == 2'b11)        err_q[0] <= 1'b1;
      if (is_rdwr && !in_ready_o)   err_q[1] <= 1'b1;
    end
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_regs_cmd_buffer.sv
// tb/tb_regs_cmd_buffer.sv - self-checking bench for regs_cmd_buffer (directed table + randomized reference model)
module tb_regs_cmd_buffer;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;
  localparam logic [1:0] C_IDLE = 2'b00;
  localparam logic [1:0] C_RD   = 2'b01;
  localparam logic [1:0] C_WR   = 2'b10;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [1:0]        in_cmd = C_IDLE;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              hold = 1'b0;
  logic              in_ready, rsp_valid;
  logic [1:0]        cmd;
  logic [ADDR_W-1:0] cmd_addr, rsp_addr;
  logic [DATA_W-1:0] cmd_data, rsp_data, rd_data;
  logic [2:0]        level;
`ifdef REGS_CMD_BUF_ERR_EN
  logic [1:0]        err;
`endif

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  regs_cmd_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk_i(clk), .rstn_i(rstn), .in_cmd_i(in_cmd), .in_addr_i(in_addr), .in_data_i(in_data),
    .in_ready_o(in_ready), .hold_i(hold), .cmd_o(cmd), .cmd_addr_o(cmd_addr), .cmd_data_o(cmd_data),
    .rd_data_i(rd_data), .rsp_valid_o(rsp_valid), .rsp_addr_o(rsp_addr), .rsp_data_o(rsp_data),
    .level_o(level)
`ifdef REGS_CMD_BUF_ERR_EN
    , .err_o(err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ctrl_regs environment: register file, read data valid exactly RD_LAT-1 cycles after sampling
  logic [DATA_W-1:0] emem [256];
  logic [RD_LAT-1:0] pv = '0;
  logic [DATA_W-1:0] pd [RD_LAT];
  assign rd_data = pv[RD_LAT-1] ? pd[RD_LAT-1] : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    for (int i = RD_LAT - 1; i > 0; i--) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
    pv[0] <= (cmd == C_RD);
    pd[0] <= emem[cmd_addr];
    if (cmd == C_WR) emem[cmd_addr] <= cmd_data;
  end

  // Reference model: a queue of commands, the command on the bus, and a count of blocked edges after a RD
  typedef struct { logic [1:0] c; logic [7:0] a; logic [31:0] d; } cmd_t;
  cmd_t        mq[$];
  cmd_t        mcur, mpend;
  bit          mcur_v = 1'b0;
  int          mblock = 0;
  bit          e_rv = 1'b0;
  logic [7:0]  e_ra;
  logic [31:0] e_rd;
  logic [31:0] mref [256];
  int          m_psize;
  bit          m_launch;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mq.delete();
      mcur_v = 1'b0;
      mblock = 0;
      e_rv   = 1'b0;
    end else begin
      m_psize  = mq.size();
      m_launch = (m_psize > 0) && !hold && (mblock == 0) && (!mcur_v || mcur.c == C_WR);
      e_rv = 1'b0;
      if (mcur_v && mcur.c == C_WR) mref[mcur.a] = mcur.d;
      if (mblock > 0) begin
        mblock--;
        if (mblock == 0) begin
          e_rv = 1'b1;
          e_ra = mpend.a;
          e_rd = mpend.d;
        end
      end
      if (mcur_v && mcur.c == C_RD) begin
        mblock  = RD_LAT;
        mpend.a = mcur.a;
        mpend.d = mref[mcur.a];
      end
      if (m_launch) begin
        mcur   = mq.pop_front();
        mcur_v = 1'b1;
      end else begin
        mcur_v = 1'b0;
      end
      if ((in_cmd == C_RD || in_cmd == C_WR) && m_psize < DEPTH)
        mq.push_back('{in_cmd, in_addr, (in_cmd == C_WR) ? in_data : 32'h0});
    end
  end

  // Cycle monitor against the model
  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_cmd",   cmd,      mcur_v ? mcur.c : C_IDLE);
      check("mon_addr",  cmd_addr, mcur_v ? mcur.a : 8'h0);
      check("mon_data",  cmd_data, (mcur_v && mcur.c == C_WR) ? mcur.d : 32'h0);
      check("mon_level", level,    mq.size());
      check("mon_ready", in_ready, mq.size() != DEPTH);
      check("mon_rsp_v", rsp_valid, e_rv);
      if (e_rv) begin
        check("mon_rsp_addr", rsp_addr, e_ra);
        check("mon_rsp_data", rsp_data, e_rd);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] c, input logic [7:0] a, input logic [31:0] d, input logic h);
    in_cmd  = c;
    in_addr = a;
    in_data = d;
    hold    = h;
  endtask

  typedef struct {
    logic [1:0] cmd; logic [7:0] addr; logic [31:0] data; logic hold;
    logic [1:0] exp_cmd; logic [7:0] exp_addr; int exp_level; logic exp_ready;
  } vec_t;
  vec_t vecs[10];

  int          n;
  bit          found;
  int          rd_t[$];
  logic [31:0] rsp_dq[$];
  logic [7:0]  rsp_aq[$];

  initial begin
    for (int i = 0; i < 256; i++) begin
      emem[i] = 32'hA5A5_0000 | i;
      mref[i] = 32'hA5A5_0000 | i;
    end
    vecs[0] = '{C_WR,   8'h10, 32'hA5A5_0010, 1'b1, C_IDLE, 8'h00, 1, 1'b1};
    vecs[1] = '{C_WR,   8'h11, 32'hA5A5_0011, 1'b1, C_IDLE, 8'h00, 2, 1'b1};
    vecs[2] = '{C_WR,   8'h12, 32'hA5A5_0012, 1'b1, C_IDLE, 8'h00, 3, 1'b1};
    vecs[3] = '{C_WR,   8'h13, 32'hA5A5_0013, 1'b1, C_IDLE, 8'h00, 4, 1'b0};
    vecs[4] = '{C_WR,   8'h14, 32'h1234_5678, 1'b1, C_IDLE, 8'h00, 4, 1'b0};
    vecs[5] = '{C_IDLE, 8'h00, 32'h0,         1'b0, C_WR,   8'h10, 3, 1'b1};
    vecs[6] = '{C_IDLE, 8'h00, 32'h0,         1'b0, C_WR,   8'h11, 2, 1'b1};
    vecs[7] = '{C_IDLE, 8'h00, 32'h0,         1'b0, C_WR,   8'h12, 1, 1'b1};
    vecs[8] = '{C_IDLE, 8'h00, 32'h0,         1'b0, C_WR,   8'h13, 0, 1'b1};
    vecs[9] = '{C_IDLE, 8'h00, 32'h0,         1'b0, C_IDLE, 8'h00, 0, 1'b1};

    // Reset then idle
    repeat (2) cyc();
    check("rst_cmd", cmd, C_IDLE);
    check("rst_level", level, 0);
    check("rst_ready", in_ready, 1);
    check("rst_rsp", rsp_valid, 0);
    rstn = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("idle_cmd", cmd, C_IDLE);
      check("idle_level", level, 0);
      check("idle_ready", in_ready, 1);
      check("idle_rsp", rsp_valid, 0);
    end

    // WR then RD of the same address
    drive(C_WR, 8'h00, 32'h0000_FFFF, 1'b0);
    cyc();
    check("wr_push_level", level, 1);
    drive(C_RD, 8'h00, 32'h1234_5678, 1'b0);
    cyc();
    check("wr_cmd", cmd, C_WR);
    check("wr_addr", cmd_addr, 8'h00);
    check("wr_data", cmd_data, 32'h0000_FFFF);
    drive(C_IDLE, 8'h00, 32'h0, 1'b0);
    cyc();
    check("rd_cmd", cmd, C_RD);
    check("rd_data_zero", cmd_data, 32'h0);
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      cyc();
      n++;
      if (cmd != C_IDLE) check("rd_gap_idle", cmd, C_IDLE);
      if (rsp_valid) found = 1'b1;
    end
    check("rsp_seen", found, 1);
    check("rsp_latency", n, RD_LAT + 1);
    check("rsp_addr", rsp_addr, 8'h00);
    check("rsp_data", rsp_data, 32'h0000_FFFF);
    cyc();
    check("rsp_one_cycle", rsp_valid, 0);

    // Hold / full / back-to-back WR table
    foreach (vecs[i]) begin
      drive(vecs[i].cmd, vecs[i].addr, vecs[i].data, vecs[i].hold);
      cyc();
      check("tbl_cmd", cmd, vecs[i].exp_cmd);
      check("tbl_addr", cmd_addr, vecs[i].exp_addr);
      check("tbl_level", level, vecs[i].exp_level);
      check("tbl_ready", in_ready, vecs[i].exp_ready);
    end

    // Two reads in a row with RD_LAT=2
    drive(C_RD, 8'h10, 32'h0, 1'b0);
    cyc();
    drive(C_RD, 8'h14, 32'h0, 1'b0);
    cyc();
    drive(C_IDLE, 8'h00, 32'h0, 1'b0);
    rd_t.delete();
    rsp_aq.delete();
    rsp_dq.delete();
    for (int i = 0; i < 20; i++) begin
      if (cmd == C_RD) rd_t.push_back(i);
      if (rsp_valid) begin
        rsp_aq.push_back(rsp_addr);
        rsp_dq.push_back(rsp_data);
      end
      cyc();
    end
    check("rr_rd_count", rd_t.size(), 2);
    check("rr_rsp_count", rsp_dq.size(), 2);
    if (rd_t.size() == 2) check("rr_idle_gap", rd_t[1] - rd_t[0] - 1, RD_LAT + 1);
    if (rsp_dq.size() == 2) begin
      check("rr_rsp0_addr", rsp_aq[0], 8'h10);
      check("rr_rsp0_data", rsp_dq[0], 32'hA5A5_0010);
      check("rr_rsp1_addr", rsp_aq[1], 8'h14);
      check("rr_rsp1_data", rsp_dq[1], 32'hA5A5_0014);
    end

    // Reset while waiting for read data with two entries queued
    drive(C_RD, 8'h20, 32'h0, 1'b0);
    cyc();
    drive(C_WR, 8'h21, 32'hA5A5_0021, 1'b0);
    cyc();
    drive(C_WR, 8'h22, 32'hA5A5_0022, 1'b0);
    cyc();
    drive(C_IDLE, 8'h00, 32'h0, 1'b0);
    check("mid_level", level, 2);
    check("mid_cmd", cmd, C_IDLE);
    #1 rstn = 1'b0;
    #1;
    check("arst_cmd", cmd, C_IDLE);
    check("arst_addr", cmd_addr, 8'h00);
    check("arst_level", level, 0);
    check("arst_ready", in_ready, 1);
    check("arst_rsp", rsp_valid, 0);
    cyc();
    cyc();
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("post_rst_rsp", rsp_valid, 0);
      check("post_rst_level", level, 0);
      check("post_rst_cmd", cmd, C_IDLE);
    end

`ifdef REGS_CMD_BUF_ERR_EN
    check("err_reset", err, 2'b00);
    drive(2'b11, 8'h05, 32'h0, 1'b0);
    cyc();
    drive(C_IDLE, 8'h00, 32'h0, 1'b0);
    check("err_bad_cmd", err, 2'b01);
    check("err_bad_level", level, 0);
    cyc();
    check("err_sticky", err, 2'b01);
    for (int i = 0; i < 5; i++) begin
      drive(C_WR, 8'(8'h30 + i), 32'hA5A5_0030 + i, 1'b1);
      cyc();
    end
    check("err_full", err, 2'b11);
    drive(C_IDLE, 8'h00, 32'h0, 1'b0);
    repeat (8) cyc();
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      drive(2'($urandom_range(0, 3)), 8'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) == 0));
      cyc();
    end
    drive(C_IDLE, 8'h00, 32'h0, 1'b0);
    repeat (20) cyc();
    check("drain_level", level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
